// File: rtl/adder_share_ctrl_pkg.sv
// Shared types for the shared-adder controller: FSM state encoding and
// requester-id width derivation.
package adder_share_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_CALC  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int id_width(input int reqs);
      return (reqs < 2) ? 1 : $clog2(reqs);
   endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after the
// pointer, wrapping from REQS-1 back to 0.
module rr_arbiter
   import adder_share_ctrl_pkg::*;
#(
   parameter int REQS = 4,
   parameter int ID_W = id_width(REQS)
) (
   input  logic [REQS-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [REQS-1:0] win,
   output logic [ID_W-1:0] win_idx,
   output logic            any
);

   logic [ID_W:0]   cand_s;
   logic            found_s;

   // Scan from the pointer; the first hit is the winner.
   always_comb begin
      win     = {REQS{1'b0}};
      win_idx = {ID_W{1'b0}};
      found_s = 1'b0;
      cand_s  = {(ID_W+1){1'b0}};
      for (int i = 0; i < REQS; i++) begin
         // ptr + i never exceeds 2*REQS-2, so one conditional subtract wraps it
         cand_s = {1'b0, ptr} + (ID_W+1)'(i);
         if (cand_s >= (ID_W+1)'(REQS)) begin
            cand_s = cand_s - (ID_W+1)'(REQS);
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && req[cand_s[ID_W-1:0]]) begin
            found_s = 1'b1;
            win_idx = cand_s[ID_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
      if (found_s) begin
         win[win_idx] = 1'b1;
      end else begin
         win = {REQS{1'b0}};
      end
      any = found_s;
   end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller time-sharing one N-bit adder among REQS requesters;
// one operation every four cycles, result tagged with the owning requester id.
module adder_share_ctrl
   import adder_share_ctrl_pkg::*;
#(
   parameter int N    = 8,
   parameter int REQS = 4,
   localparam int ID_W = id_width(REQS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REQS-1:0]   req,
   input  logic [REQS*N-1:0] a_bus,
   input  logic [REQS*N-1:0] b_bus,
   output logic [REQS-1:0]   gnt,
   output logic              busy,
   output logic [N-1:0]      res,
   output logic              carry,
   output logic              res_valid,
   output logic [ID_W-1:0]   res_id
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [ID_W-1:0]   ptr_r;
   logic [ID_W-1:0]   ptr_nxt_s;
   logic [ID_W-1:0]   id_r;
   logic [N-1:0]      a_lat_r;
   logic [N-1:0]      b_lat_r;
   logic [N:0]        sum_s;
   logic [REQS-1:0]   win_s;
   logic [ID_W-1:0]   win_idx_s;
   logic              any_s;
   logic [REQS-1:0]   gnt_r;
   logic              busy_r;
   logic [N-1:0]      res_r;
   logic              carry_r;
   logic              res_valid_r;
   logic [ID_W-1:0]   res_id_r;

   rr_arbiter #(
      .REQS (REQS),
      .ID_W (ID_W)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_r),
      .win     (win_s),
      .win_idx (win_idx_s),
      .any     (any_s)
   );

   // Adder on operands latched at grant time only.
   assign sum_s = {1'b0, a_lat_r} + {1'b0, b_lat_r};

   // Pointer moves one past the winner, wrapping at REQS.
   always_comb begin
      if (win_idx_s == ID_W'(REQS - 1)) begin
         ptr_nxt_s = {ID_W{1'b0}};
      end else begin
         ptr_nxt_s = win_idx_s + ID_W'(1);
      end
   end

   // Next-state logic: IDLE waits for a request, then a fixed three-step walk.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_s) begin
               state_nxt_s = ST_GRANT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GRANT: state_nxt_s = ST_CALC;
         ST_CALC:  state_nxt_s = ST_DONE;
         ST_DONE:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand latches, arbitration pointer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r       <= {ID_W{1'b0}};
         id_r        <= {ID_W{1'b0}};
         a_lat_r     <= {N{1'b0}};
         b_lat_r     <= {N{1'b0}};
         gnt_r       <= {REQS{1'b0}};
         busy_r      <= 1'b0;
         res_r       <= {N{1'b0}};
         carry_r     <= 1'b0;
         res_valid_r <= 1'b0;
         res_id_r    <= {ID_W{1'b0}};
      end else begin
         busy_r <= (state_nxt_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (any_s) begin
                  a_lat_r <= a_bus[win_idx_s*N +: N];
                  b_lat_r <= b_bus[win_idx_s*N +: N];
                  id_r    <= win_idx_s;
                  gnt_r   <= win_s;
                  ptr_r   <= ptr_nxt_s;
               end else begin
                  gnt_r   <= {REQS{1'b0}};
               end
            end
            ST_GRANT: begin
               gnt_r            <= {REQS{1'b0}};
               {carry_r, res_r} <= sum_s;
            end
            ST_CALC: begin
               res_valid_r <= 1'b1;
               res_id_r    <= id_r;
            end
            ST_DONE: begin
               res_valid_r <= 1'b0;
            end
            default: begin
               gnt_r       <= {REQS{1'b0}};
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_r;
   assign busy      = busy_r;
   assign res       = res_r;
   assign carry     = carry_r;
   assign res_valid = res_valid_r;
   assign res_id    = res_id_r;

endmodule
